id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage MIPS32 core, directly downstream of the main decoder.
- Captures the decoder control flags, register-file read data, the sign-extended immediate and the register specifiers, and presents them to EX one cycle later.
- Owns load-use hazard detection: on a hazard it inserts a bubble and tells PC/IF/ID to hold.
- Also handles branch/jump flush and global memory stall, and keeps a saturating bubble counter.

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS32 core.
// Captures decoder control, register read data, immediate and register
// specifiers for EX. Detects load-use hazards (bubble + hold of PC/IF/ID),
// squashes on branch/jump flush, freezes on data-memory stall, and keeps a
// saturating count of hazard bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_alu_op,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_reg_dest,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_op,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_reg_dest,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              hold_if_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // One ID/EX entry; an all-zero entry is a bubble.
  typedef struct packed {
    logic [3:0]        alu_op;
    logic              mem_write;
    logic              reg_write;
    logic              reg_dest;
    logic              alu_src;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } stage_t;

  stage_t            w_id_p0;
  stage_t            r_ex_p1;
  logic              r_vld_p1;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_rt_used;
  logic              w_hazard;
  logic              w_bubble;

  // Saturating increment: an all-ones count stays all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---- p0: ID inputs, hazard detection ----
  assign w_id_p0 = '{alu_op: id_alu_op, mem_write: id_mem_write,
                     reg_write: id_reg_write, reg_dest: id_reg_dest,
                     alu_src: id_alu_src, mem_to_reg: id_mem_to_reg,
                     branch: id_branch, jump: id_jump,
                     rd1: id_rd1, rd2: id_rd2, imm: id_imm, pc4: id_pc4,
                     rs: id_rs, rt: id_rt, rd: id_rd};

  // rt is a source only for R-type (writes rd), stores and branches.
  assign w_rt_used = id_reg_dest | id_mem_write | id_branch;

  // A load in EX whose target is read by the ID instruction; $0 never conflicts.
  assign w_hazard = r_vld_p1 && r_ex_p1.mem_to_reg && (r_ex_p1.rt != 5'd0) &&
                    id_valid &&
                    ((r_ex_p1.rt == id_rs) || ((r_ex_p1.rt == id_rt) && w_rt_used));

  assign w_bubble   = flush | w_hazard;
  // Flush squashes the held instruction anyway, so it cancels the hold.
  assign hold_if_id = mem_stall | (w_hazard & ~flush);

  // Stage register: reset, freeze on stall, bubble on flush/hazard, else load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_p1  <= '0;
      r_vld_p1 <= 1'b0;
    end else if (!mem_stall) begin
      if (w_bubble) begin
        r_ex_p1  <= '0;
        r_vld_p1 <= 1'b0;
      end else begin
        r_ex_p1  <= w_id_p0;
        r_vld_p1 <= id_valid;
      end
    end
  end

  // Bubble counter: only hazard bubbles count, flush squashes do not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!mem_stall && !flush && w_hazard) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  // ---- p1: EX-facing outputs ----
  assign ex_valid      = r_vld_p1;
  assign ex_alu_op     = r_ex_p1.alu_op;
  assign ex_mem_write  = r_ex_p1.mem_write;
  assign ex_reg_write  = r_ex_p1.reg_write;
  assign ex_reg_dest   = r_ex_p1.reg_dest;
  assign ex_alu_src    = r_ex_p1.alu_src;
  assign ex_mem_to_reg = r_ex_p1.mem_to_reg;
  assign ex_branch     = r_ex_p1.branch;
  assign ex_jump       = r_ex_p1.jump;
  assign ex_rd1        = r_ex_p1.rd1;
  assign ex_rd2        = r_ex_p1.rd2;
  assign ex_imm        = r_ex_p1.imm;
  assign ex_pc4        = r_ex_p1.pc4;
  assign ex_rs         = r_ex_p1.rs;
  assign ex_rt         = r_ex_p1.rt;
  assign ex_rd         = r_ex_p1.rd;
  assign bubble_cnt    = r_bubble_cnt;

endmodule
